upper_arb: RTL
==============

# upper_arb

Round-robin scheduler sharing one combinational `to_upper` converter between two byte requesters. It accepts bytes over valid/ready handshakes and drives the converter input. It holds that input stable for a programmable settle window, sized to cover the converter's roughly 25 ns propagation delay, then captures the converter output. Each captured result is returned with the id of the requester that sent the byte. The block sits between the text-stream sources and the single shared `to_upper` instance, whose `A_in`/`A_out` connect to `conv_a_in`/`conv_a_out`.

## Interface
- `SETTLE_CYCLES`, default 3: clock cycles `conv_a_in` is held before `conv_a_out` is sampled. Legal range 1..15.
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 byte.
- `req0_ready`  out  1  requester 0 byte accepted this cycle (when `req0_valid` is also high).
- `req1_valid` / `req1_data` / `req1_ready`: the same signals for requester 1.
- `conv_a_in`  out  8  registered drive to the converter `A_in`.
- `conv_a_out`  in  8  converter `A_out`.
- `res_valid`  out  1  result available.
- `res_data`  out  8  converted byte.
- `res_id`  out  1  requester that sent the byte.
- `res_ready`  in  1  result consumer accepts the result.

## Operation
- States:
  - IDLE: no byte in flight.
  - SETTLE: converter input is being held; a 4-bit counter `cnt` runs.
  - RESULT: `res_valid` is high.
- Grant, computed combinationally in IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester other than `last_grant` is granted.
- Ready: `reqN_ready = (state==IDLE) && grant==N`. It is low in every other state.
- Accept happens on an edge where `reqN_valid && reqN_ready`. On that edge:
  - `conv_a_in <= reqN_data`
  - `res_id <= N`
  - `last_grant <= N`
  - `cnt <= 0`
  - state goes to SETTLE.
- SETTLE, on each edge:
  - If `cnt == SETTLE_CYCLES-1`: `res_data <= conv_a_out`, `res_valid <= 1`, state goes to RESULT.
  - Otherwise `cnt <= cnt+1`.
- RESULT:
  - `res_data` and `res_id` stay stable while `res_valid && !res_ready`.
  - On the edge where `res_ready` is high: `res_valid <= 0`, state goes to IDLE.
- `conv_a_in` keeps its last value in IDLE and RESULT. It never changes during SETTLE.
- Requesters must hold `reqN_data` stable while `reqN_valid` is high and ready is low. The block does not check this.
- The block does no arithmetic. Case conversion is done entirely by `to_upper`; the block passes bytes through unchanged.

## Timing
- Reset values:
  - State IDLE.
  - `conv_a_in`=0x00, `res_data`=0x00, `res_valid`=0, `res_id`=0.
  - `req0_ready`/`req1_ready` follow the IDLE grant equation.
  - `last_grant`=1, so requester 0 wins the first tie.
- Latency: accept on edge k gives `res_valid` high after edge k+`SETTLE_CYCLES`.
- Throughput with `res_ready` held high: one byte every `SETTLE_CYCLES`+2 cycles. This is one RESULT cycle plus one IDLE cycle.
- Reset asserted in any state returns to reset values on that edge. The in-flight byte is discarded and no result is emitted for it.
- A requester deasserting valid while in IDLE and not yet accepted has no effect.
- `res_ready` high outside RESULT is ignored.

## Configuration
- `UPPER_ARB_FASTPATH_EN` defined:
  - A byte outside 0x61..0x7A skips SETTLE.
  - On its accept edge: `res_data <= reqN_data`, `res_valid <= 1`, state goes to RESULT. `conv_a_in` is still loaded.
  - Latency is 1 cycle; period is 2 cycles.
  - Bytes in 0x61..0x7A follow the normal path.
- Not defined: every byte takes the SETTLE path.

## Test plan
- `SETTLE_CYCLES`=3, req0 sends 0x68 → `res_valid` rises 3 edges after accept with `res_data`=0x48, `res_id`=0.
- Out of reset, req0=0x61 and req1=0x7A both valid, `res_ready`=1 → results in order 0x41/id0 then 0x5A/id1. A second byte from req0 is served after req1 (alternation).
- Backpressure: result 0x47 pending with `res_ready` low for 5 cycles → `res_valid`, `res_data`=0x47 and `res_id` stay stable, both readys stay 0. On the `res_ready` edge the block returns to IDLE.
- `rst` asserted during SETTLE with 0x6D in flight → next cycle all outputs are at reset values and no result appears. A following 0x6D yields 0x4D.
- Inputs 0x28, 0xB7, 0x7B → results equal the `to_upper` output (0x28, 0xB7, 0x7B). With `UPPER_ARB_FASTPATH_EN`, `res_valid` rises 1 edge after accept. Without it, `res_valid` rises `SETTLE_CYCLES` edges after accept.
- `SETTLE_CYCLES`=1, continuous req1 stream 0x41, 0x7A, 0x6D → results 0x41, 0x5A, 0x4D, one every 3 cycles.

Source files
------------

// File: rtl/upper_arb.sv
// upper_arb: round-robin scheduler sharing one combinational to_upper
// converter between two byte requesters. The converter input is held for
// SETTLE_CYCLES clocks before its output is captured and returned together
// with the id of the requester that sent the byte.
// Optional feature: define UPPER_ARB_FASTPATH_EN to let bytes outside
// 0x61..0x7A bypass the settle window; they need no conversion.
module upper_arb #(
   parameter int SETTLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic [7:0] conv_a_in,
   input  logic [7:0] conv_a_out,
   output logic       res_valid,
   output logic [7:0] res_data,
   output logic       res_id,
   input  logic       res_ready
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESULT = 2'd2
   } state_t;

   // Terminal value of the settle counter.
   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

`ifdef UPPER_ARB_FASTPATH_EN
   // Bytes in the lower-case letter range are the only ones the converter changes.
   function automatic logic is_lower(input logic [7:0] b);
      return (b >= 8'h61) && (b <= 8'h7A);
   endfunction
`endif

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] conv_a_in_q, conv_a_in_d;
   logic [7:0] res_data_q, res_data_d;
   logic       res_valid_q, res_valid_d;
   logic       res_id_q, res_id_d;
   logic       last_grant_q, last_grant_d;

   logic       grant_s;
   logic       accept_s;
   logic [7:0] acc_data_s;

   // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
   always_comb begin
      grant_s = ~last_grant_q;
      if (req0_valid && !req1_valid) begin
         grant_s = 1'b0;
      end else if (!req0_valid && req1_valid) begin
         grant_s = 1'b1;
      end else begin
         grant_s = ~last_grant_q;
      end
   end

   assign req0_ready = (state_q == ST_IDLE) && (grant_s == 1'b0);
   assign req1_ready = (state_q == ST_IDLE) && (grant_s == 1'b1);
   assign accept_s   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign acc_data_s = grant_s ? req1_data : req0_data;

   // Next-state and datapath: accept, hold for the settle window, then present the result.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      conv_a_in_d  = conv_a_in_q;
      res_data_d   = res_data_q;
      res_valid_d  = res_valid_q;
      res_id_d     = res_id_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               conv_a_in_d  = acc_data_s;
               res_id_d     = grant_s;
               last_grant_d = grant_s;
               cnt_d        = 4'd0;
               state_d      = ST_SETTLE;
`ifdef UPPER_ARB_FASTPATH_EN
               if (!is_lower(acc_data_s)) begin
                  res_data_d  = acc_data_s;
                  res_valid_d = 1'b1;
                  state_d     = ST_RESULT;
               end else begin
                  state_d     = ST_SETTLE;
               end
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == CNT_LAST) begin
               res_data_d  = conv_a_out;
               res_valid_d = 1'b1;
               state_d     = ST_RESULT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_RESULT;
            end
         end
         default: begin
            res_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset; the first tie goes to requester 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         conv_a_in_q  <= 8'h00;
         res_data_q   <= 8'h00;
         res_valid_q  <= 1'b0;
         res_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         conv_a_in_q  <= conv_a_in_d;
         res_data_q   <= res_data_d;
         res_valid_q  <= res_valid_d;
         res_id_q     <= res_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign conv_a_in = conv_a_in_q;
   assign res_data  = res_data_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;

endmodule
